lsu_axi_rd_dma: RTL and testbench
=================================

LSU_AXI_RD_DMA -- requirements
Module: lsu_axi_rd_dma

Interface
REQ-001 SHALL have parameter DATA_W, default 64, the AXI R data width and RAM write width in bits (64/128/256).
REQ-002 SHALL have parameter ID_W, default 8, the AXI ID width.
REQ-003 SHALL have parameter DADDR_W, default 32, the DRAM byte-address width.
REQ-004 SHALL have parameter RADDR_W, default 12, the on-chip RAM word-address width.
REQ-005 SHALL have parameter MAX_OUTST, default 4, the number of AR bursts outstanding at once (1..15).
REQ-006 SHALL have parameter RD_ID, default 0, the constant ARID value.
REQ-007 SHALL provide these ports, each given as name, direction, width and meaning:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- alu_lsu_rd_vld  in  1  command valid.
- lsu_alu_rd_rdy  out  1  command ready.
- alu_lsu_dram_addr  in  DADDR_W  first row byte address.
- alu_lsu_num  in  8  row count.
- alu_lsu_len  in  8  beats per row minus 1.
- alu_lsu_str  in  16  row stride in bytes.
- alu_lsu_ram_addr  in  RADDR_W  first RAM word.
- alu_lsu_ram_sel  in  2  target RAM: 0=iram, 1=wram, 2=oram.
- lsu_axi_arid  out  ID_W.
- lsu_axi_araddr  out  DADDR_W.
- lsu_axi_arlen  out  8.
- lsu_axi_arsize  out  3.
- lsu_axi_arburst  out  2.
- lsu_axi_arvld  out  1.
- axi_lsu_arrdy  in  1.
- axi_lsu_rid  in  ID_W.
- axi_lsu_rdata  in  DATA_W.
- axi_lsu_rresp  in  2.
- axi_lsu_rlast  in  1.
- axi_lsu_rvld  in  1.
- lsu_axi_rrdy  out  1.
- lsu_ram_wr_en  out  1.
- lsu_ram_wr_sel  out  2.
- lsu_ram_wr_addr  out  RADDR_W.
- lsu_ram_wr_data  out  DATA_W.
- lsu_alu_rd_done  out  1  one-cycle completion pulse.
- lsu_alu_rd_err  out  1  error flag, valid with done.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-009 SHALL assert lsu_alu_rd_rdy only in IDLE, and SHALL latch all command fields on vld&rdy.
REQ-010 SHALL go from IDLE to DONE, with no AR issued, when the accepted command has alu_lsu_num=0.
REQ-011 SHALL assert arvld in ISSUE, first in the cycle after acceptance.
REQ-012 SHALL drive araddr = dram_addr + row*str for the row-th AR, computed modulo 2^DADDR_W.
REQ-013 SHALL drive arlen = len, arsize = log2(DATA_W/8), arburst = INCR (2'b01) and arid = RD_ID.
REQ-014 SHALL hold AR payload stable while arvld=1 and arrdy=0.
REQ-015 SHALL deassert arvld while the outstanding count equals MAX_OUTST.
REQ-016 SHALL increment the outstanding count on AR handshake and decrement it on an R handshake with rlast=1; when both occur in one cycle the count SHALL stay unchanged.
REQ-017 SHALL move from ISSUE to DRAIN on the AR handshake for the last row, and from DRAIN to DONE on the R handshake that brings the outstanding count to 0.
REQ-018 SHALL assert rrdy only in ISSUE and DRAIN, and SHALL hold rrdy=0 in IDLE and DONE.
REQ-019 SHALL register each R handshake into a RAM write one cycle later: wr_en=1, wr_sel=ram_sel, wr_data=rdata, wr_addr = ram_addr + beat index, wrapping modulo 2^RADDR_W.
REQ-020 SHALL set the sticky error on any handshaken beat with rresp!=0, with rid!=RD_ID, with rlast=1 before beat len, or with rlast=0 on beat len; that beat SHALL still be written.
REQ-021 SHALL pulse lsu_alu_rd_done for exactly one cycle in DONE, coincident with the final RAM write, with rd_err equal to the sticky error; the error SHALL clear on the next command acceptance.
REQ-022 SHALL produce no write, no done and no error change for R beats that arrive while rrdy=0.

Reset
REQ-023 SHALL reset asynchronously on rst=1 to: IDLE, all counters 0, error 0, all valid/enable outputs 0, address/data outputs 0, rd_rdy=0 during reset.
REQ-024 SHALL, on reset asserted mid-transfer, abandon all outstanding bursts, issue no RAM write and no done, and accept a new command in the first cycle after release.

Structure
REQ-025 SHALL take the FSM state enum, the ram_sel encodings, AXI_BURST_INCR and the AXI_RESP_OKAY constant from the shared package lsu_pkg.
REQ-026 SHALL place row/stride address generation in one sub-module, lsu_rd_addr_gen, which holds the row counter and an accumulating araddr register with no multiplier.

Verification
REQ-027 SHALL cover: addr=0x1000, num=3, len=3, str=0x100, ram_addr=0x10, sel=wram, arrdy=1 -> ARs to 0x1000/0x1100/0x1200, 12 writes to 0x10..0x1B, done with err=0.
REQ-028 SHALL cover: MAX_OUTST=2, num=5, R delayed 20 cycles -> never more than 2 outstanding, arvld=0 while at limit, done after the 5th rlast.
REQ-029 SHALL cover: num=0 -> no arvld, done one cycle after acceptance, err=0.
REQ-030 SHALL cover: num=2, len=1, rresp=2'b10 on beat 2 -> all 4 beats written, done with err=1; the next command's done has err=0.
REQ-031 SHALL cover: ram_addr=0xFFE, 4 beats, RADDR_W=12 -> writes to 0xFFE, 0xFFF, 0x000, 0x001.
REQ-032 SHALL cover: rst=1 after 2 of 4 ARs -> outputs reach reset values immediately, no done, and a new command is accepted cleanly after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and AXI/RAM constants for the LSU read-DMA path.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RAM_SEL_IRAM   = 2'd0;
    localparam logic [1:0] RAM_SEL_WRAM   = 2'd1;
    localparam logic [1:0] RAM_SEL_ORAM   = 2'd2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/lsu_rd_addr_gen.sv
// Row address generator: accumulates base + row*stride one AR at a time.
module lsu_rd_addr_gen #(
    parameter int DADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DADDR_W-1:0] base,
    input  logic [15:0]        str,
    input  logic [7:0]         num,
    input  logic               step,
    output logic [DADDR_W-1:0] araddr,
    output logic               last_row
);

    logic [7:0] row_q;
    logic [7:0] num_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            araddr <= '0;
            row_q  <= '0;
            num_q  <= '0;
        end else if (load) begin
            araddr <= base;
            row_q  <= '0;
            num_q  <= num;
        end else if (step) begin
            // Stride addition replaces a row*str multiply; wraps at 2^DADDR_W.
            araddr <= araddr + DADDR_W'(str);
            row_q  <= row_q + 8'd1;
        end
    end

    assign last_row = (row_q == num_q - 8'd1);

endmodule

// File: rtl/lsu_axi_rd_dma.sv
// Strided multi-row AXI read DMA that streams R beats into an on-chip RAM.
module lsu_axi_rd_dma
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ID_W      = 8,
    parameter int DADDR_W   = 32,
    parameter int RADDR_W   = 12,
    parameter int MAX_OUTST = 4,
    parameter int RD_ID     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_lsu_rd_vld,
    output logic               lsu_alu_rd_rdy,
    input  logic [DADDR_W-1:0] alu_lsu_dram_addr,
    input  logic [7:0]         alu_lsu_num,
    input  logic [7:0]         alu_lsu_len,
    input  logic [15:0]        alu_lsu_str,
    input  logic [RADDR_W-1:0] alu_lsu_ram_addr,
    input  logic [1:0]         alu_lsu_ram_sel,
    output logic [ID_W-1:0]    lsu_axi_arid,
    output logic [DADDR_W-1:0] lsu_axi_araddr,
    output logic [7:0]         lsu_axi_arlen,
    output logic [2:0]         lsu_axi_arsize,
    output logic [1:0]         lsu_axi_arburst,
    output logic               lsu_axi_arvld,
    input  logic               axi_lsu_arrdy,
    input  logic [ID_W-1:0]    axi_lsu_rid,
    input  logic [DATA_W-1:0]  axi_lsu_rdata,
    input  logic [1:0]         axi_lsu_rresp,
    input  logic               axi_lsu_rlast,
    input  logic               axi_lsu_rvld,
    output logic               lsu_axi_rrdy,
    output logic               lsu_ram_wr_en,
    output logic [1:0]         lsu_ram_wr_sel,
    output logic [RADDR_W-1:0] lsu_ram_wr_addr,
    output logic [DATA_W-1:0]  lsu_ram_wr_data,
    output logic               lsu_alu_rd_done,
    output logic               lsu_alu_rd_err
);

    localparam logic [2:0]      AR_SIZE   = 3'($clog2(DATA_W / 8));
    localparam logic [3:0]      OUTST_MAX = 4'(MAX_OUTST);
    localparam logic [ID_W-1:0] ARID      = ID_W'(RD_ID);

    state_t             state_q, state_d;
    logic [7:0]         len_q;
    logic [7:0]         beat_q;
    logic [1:0]         sel_q;
    logic [RADDR_W-1:0] wr_ptr_q;
    logic [3:0]         outst_q;
    logic               err_q;
    logic               accept, ar_hs, r_hs, rlast_hs, last_row, beat_err;

    assign lsu_alu_rd_rdy  = (state_q == ST_IDLE) && !rst;
    assign accept          = alu_lsu_rd_vld && lsu_alu_rd_rdy;
    assign lsu_axi_arvld   = (state_q == ST_ISSUE) && (outst_q != OUTST_MAX);
    assign lsu_axi_rrdy    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign ar_hs           = lsu_axi_arvld && axi_lsu_arrdy;
    assign r_hs            = axi_lsu_rvld && lsu_axi_rrdy;
    assign rlast_hs        = r_hs && axi_lsu_rlast;

    assign lsu_axi_arid    = ARID;
    assign lsu_axi_arlen   = len_q;
    assign lsu_axi_arsize  = AR_SIZE;
    assign lsu_axi_arburst = AXI_BURST_INCR;
    assign lsu_alu_rd_done = (state_q == ST_DONE);
    assign lsu_alu_rd_err  = err_q;

    // rlast must coincide exactly with beat index len of each burst.
    assign beat_err = (axi_lsu_rresp != AXI_RESP_OKAY) || (axi_lsu_rid != ARID) ||
                      (axi_lsu_rlast != (beat_q == len_q));

    lsu_rd_addr_gen #(
        .DADDR_W (DADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .base     (alu_lsu_dram_addr),
        .str      (alu_lsu_str),
        .num      (alu_lsu_num),
        .step     (ar_hs),
        .araddr   (lsu_axi_araddr),
        .last_row (last_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (alu_lsu_num == 8'd0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (ar_hs && last_row) state_d = ST_DRAIN;
            ST_DRAIN: if (rlast_hs && outst_q == 4'd1) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            beat_q   <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                len_q    <= alu_lsu_len;
                sel_q    <= alu_lsu_ram_sel;
                wr_ptr_q <= alu_lsu_ram_addr;
                beat_q   <= '0;
                err_q    <= 1'b0;
            end else if (r_hs) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                beat_q   <= axi_lsu_rlast ? 8'd0 : beat_q + 8'd1;
                if (beat_err) err_q <= 1'b1;
            end
            case ({ar_hs, rlast_hs})
                2'b10:   outst_q <= outst_q + 4'd1;
                2'b01:   outst_q <= outst_q - 4'd1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    // RAM write stage: one cycle behind the R handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_ram_wr_en   <= 1'b0;
            lsu_ram_wr_sel  <= '0;
            lsu_ram_wr_addr <= '0;
            lsu_ram_wr_data <= '0;
        end else begin
            lsu_ram_wr_en <= r_hs;
            if (r_hs) begin
                lsu_ram_wr_sel  <= sel_q;
                lsu_ram_wr_addr <= wr_ptr_q;
                lsu_ram_wr_data <= axi_lsu_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi_rd_dma.sv
// Scoreboard bench: AXI slave model feeds R beats, expected ARs/writes/dones come from a row/beat model.
module tb_lsu_axi_rd_dma;

    localparam int DATA_W = 64, ID_W = 8, DADDR_W = 32, RADDR_W = 12, MAX_OUTST = 2, RD_ID = 0;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_lsu_rd_vld = 1'b0;
    logic               lsu_alu_rd_rdy;
    logic [DADDR_W-1:0] alu_lsu_dram_addr = '0;
    logic [7:0]         alu_lsu_num = '0, alu_lsu_len = '0;
    logic [15:0]        alu_lsu_str = '0;
    logic [RADDR_W-1:0] alu_lsu_ram_addr = '0;
    logic [1:0]         alu_lsu_ram_sel = '0;
    logic [ID_W-1:0]    lsu_axi_arid;
    logic [DADDR_W-1:0] lsu_axi_araddr;
    logic [7:0]         lsu_axi_arlen;
    logic [2:0]         lsu_axi_arsize;
    logic [1:0]         lsu_axi_arburst;
    logic               lsu_axi_arvld;
    logic               axi_lsu_arrdy = 1'b0;
    logic [ID_W-1:0]    axi_lsu_rid = '0;
    logic [DATA_W-1:0]  axi_lsu_rdata = '0;
    logic [1:0]         axi_lsu_rresp = '0;
    logic               axi_lsu_rlast = 1'b0;
    logic               axi_lsu_rvld = 1'b0;
    logic               lsu_axi_rrdy;
    logic               lsu_ram_wr_en;
    logic [1:0]         lsu_ram_wr_sel;
    logic [RADDR_W-1:0] lsu_ram_wr_addr;
    logic [DATA_W-1:0]  lsu_ram_wr_data;
    logic               lsu_alu_rd_done;
    logic               lsu_alu_rd_err;

    always #5 clk = ~clk;

    lsu_axi_rd_dma #(
        .DATA_W(DATA_W), .ID_W(ID_W), .DADDR_W(DADDR_W), .RADDR_W(RADDR_W),
        .MAX_OUTST(MAX_OUTST), .RD_ID(RD_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_lsu_rd_vld(alu_lsu_rd_vld), .lsu_alu_rd_rdy(lsu_alu_rd_rdy),
        .alu_lsu_dram_addr(alu_lsu_dram_addr), .alu_lsu_num(alu_lsu_num),
        .alu_lsu_len(alu_lsu_len), .alu_lsu_str(alu_lsu_str),
        .alu_lsu_ram_addr(alu_lsu_ram_addr), .alu_lsu_ram_sel(alu_lsu_ram_sel),
        .lsu_axi_arid(lsu_axi_arid), .lsu_axi_araddr(lsu_axi_araddr),
        .lsu_axi_arlen(lsu_axi_arlen), .lsu_axi_arsize(lsu_axi_arsize),
        .lsu_axi_arburst(lsu_axi_arburst), .lsu_axi_arvld(lsu_axi_arvld),
        .axi_lsu_arrdy(axi_lsu_arrdy), .axi_lsu_rid(axi_lsu_rid),
        .axi_lsu_rdata(axi_lsu_rdata), .axi_lsu_rresp(axi_lsu_rresp),
        .axi_lsu_rlast(axi_lsu_rlast), .axi_lsu_rvld(axi_lsu_rvld),
        .lsu_axi_rrdy(lsu_axi_rrdy), .lsu_ram_wr_en(lsu_ram_wr_en),
        .lsu_ram_wr_sel(lsu_ram_wr_sel), .lsu_ram_wr_addr(lsu_ram_wr_addr),
        .lsu_ram_wr_data(lsu_ram_wr_data), .lsu_alu_rd_done(lsu_alu_rd_done),
        .lsu_alu_rd_err(lsu_alu_rd_err)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [11:0] addr; logic [63:0] data; logic [1:0] sel; } wr_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; int rdy_cyc; } pend_t;

    ar_t   exp_ar[$];
    wr_t   exp_wr[$];
    bit    exp_done[$];
    pend_t pend[$];

    int compared = 0, mismatched = 0;
    int cyc = 0, outst = 0, peak = 0, beat = 0, gbeat = 0, done_cnt = 0, ar_cnt = 0;
    int bad_beat = -1, bad_kind = 0, rdelay = 0, arrdy_mode = 0, rgap = 0;
    logic [31:0] salt = '0;
    bit prev_stall = 1'b0;
    logic [39:0] prev_ar = '0;

    function automatic logic [63:0] beat_data(logic [31:0] a, int b, logic [31:0] s);
        return {(a + 32'(b) * 32'd8) ^ s, s ^ (32'(b) * 32'h9E3779B9)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // AXI slave: accepts ARs, returns R beats after rdelay cycles, checks AR channel rules.
    initial begin
        logic ar_hs, r_hs;
        ar_t e;
        forever begin
            @(negedge clk);
            ar_hs = 1'b0;
            r_hs  = 1'b0;
            if (!rst) begin
                ar_hs = lsu_axi_arvld && axi_lsu_arrdy;
                r_hs  = axi_lsu_rvld && lsu_axi_rrdy;
                if (prev_stall) begin
                    check("ar_hold_vld", lsu_axi_arvld, 1);
                    check("ar_hold_payload", {lsu_axi_araddr, lsu_axi_arlen}, prev_ar);
                end
                if (outst >= MAX_OUTST) check("arvld_at_limit", lsu_axi_arvld, 0);
                if (ar_hs) begin
                    if (exp_ar.size() == 0) fail_evt("unexpected_ar");
                    else begin
                        e = exp_ar.pop_front();
                        check("araddr", lsu_axi_araddr, e.addr);
                        check("arlen", lsu_axi_arlen, e.len);
                        check("ar_const", {lsu_axi_arid, lsu_axi_arsize, lsu_axi_arburst},
                              {8'(RD_ID), 3'd3, 2'b01});
                    end
                    pend.push_back('{lsu_axi_araddr, lsu_axi_arlen, cyc + rdelay});
                    outst++;
                    ar_cnt++;
                    if (outst > peak) peak = outst;
                end
                if (r_hs) begin
                    if (axi_lsu_rlast) begin
                        beat = 0;
                        outst--;
                        if (pend.size() != 0) void'(pend.pop_front());
                    end else beat++;
                    gbeat++;
                end
                prev_stall = lsu_axi_arvld && !axi_lsu_arrdy;
                prev_ar    = {lsu_axi_araddr, lsu_axi_arlen};
            end else prev_stall = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            axi_lsu_arrdy = (arrdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
            if (axi_lsu_rvld && !r_hs && pend.size() != 0) begin
                // beat still waiting for its handshake: payload unchanged
            end else if (pend.size() != 0 && cyc >= pend[0].rdy_cyc && $urandom_range(0, 99) >= rgap) begin
                axi_lsu_rvld  = 1'b1;
                axi_lsu_rdata = beat_data(pend[0].addr, beat, salt);
                axi_lsu_rlast = (beat == int'(pend[0].len));
                axi_lsu_rresp = (gbeat == bad_beat && bad_kind == 0) ? 2'b10 : 2'b00;
                axi_lsu_rid   = (gbeat == bad_beat && bad_kind == 1) ? 8'h5A : 8'(RD_ID);
            end else begin
                axi_lsu_rvld  = 1'b0;
                axi_lsu_rlast = 1'b0;
                axi_lsu_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: RAM writes and completion against the scoreboard.
    initial begin
        wr_t w;
        bit  e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (lsu_ram_wr_en) begin
                    if (exp_wr.size() == 0) fail_evt("unexpected_write");
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", lsu_ram_wr_addr, w.addr);
                        check("wr_data", lsu_ram_wr_data, w.data);
                        check("wr_sel", lsu_ram_wr_sel, w.sel);
                    end
                end
                if (lsu_alu_rd_done) begin
                    if (exp_done.size() == 0) fail_evt("unexpected_done");
                    else begin
                        e = exp_done.pop_front();
                        check("done_err", lsu_alu_rd_err, e);
                        check("done_with_last_write", exp_wr.size(), 0);
                        check("done_rrdy", lsu_axi_rrdy, 0);
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input logic [7:0] n, input logic [7:0] l,
                             input logic [15:0] s, input logic [11:0] ra, input logic [1:0] sel,
                             input int bad, input int kind, output int tries);
        int bpr;
        bit ok;
        bpr = int'(l) + 1;
        ok = 1'b0;
        tries = 0;
        salt = $urandom;
        bad_beat = bad;
        bad_kind = kind;
        gbeat = 0;
        for (int r = 0; r < int'(n); r++) exp_ar.push_back('{a + 32'(r) * 32'(s), l});
        for (int g = 0; g < int'(n) * bpr; g++)
            exp_wr.push_back('{12'(32'(ra) + 32'(g)),
                               beat_data(a + 32'(g / bpr) * 32'(s), g % bpr, salt), sel});
        exp_done.push_back(bad >= 0);
        alu_lsu_dram_addr = a;  alu_lsu_num = n;  alu_lsu_len = l;
        alu_lsu_str = s;  alu_lsu_ram_addr = ra;  alu_lsu_ram_sel = sel;
        alu_lsu_rd_vld = 1'b1;
        while (!ok && tries < 50) begin
            @(negedge clk);
            tries++;
            if (lsu_alu_rd_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        alu_lsu_rd_vld = 1'b0;
        check("cmd_accept", ok, 1);
        @(negedge clk);
        check("rdy_busy", lsu_alu_rd_rdy, 0);
        if (n != 8'd0) check("arvld_first_cycle", lsu_axi_arvld, 1);
        else begin
            check("num0_done", lsu_alu_rd_done, 1);
            check("num0_no_arvld", lsu_axi_arvld, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target);
        int i;
        i = 0;
        while (done_cnt < target && i < 5000) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (done_cnt < target) begin
            mismatched++;
            compared++;
            $display("FAIL done_timeout: done count %0d required %0d", done_cnt, target);
        end
        check("ar_all_issued", exp_ar.size(), 0);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [7:0] n, input logic [7:0] l,
                           input logic [15:0] s, input logic [11:0] ra, input logic [1:0] sel,
                           input int bad, input int kind);
        int t, target;
        target = done_cnt + 1;
        issue_cmd(a, n, l, s, ra, sel, bad, kind, t);
        wait_done(target);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_outputs", {lsu_axi_arvld, lsu_axi_rrdy, lsu_ram_wr_en, lsu_alu_rd_done,
                              lsu_alu_rd_err, lsu_alu_rd_rdy}, 6'b0);
        check("rst_araddr", lsu_axi_araddr, 0);
        check("rst_wr_addr", lsu_ram_wr_addr, 0);
        check("rst_wr_data", lsu_ram_wr_data, 0);
        exp_ar.delete();
        exp_wr.delete();
        exp_done.delete();
        pend.delete();
        outst = 0;
        beat = 0;
        gbeat = 0;
        prev_stall = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t, base, i, n, l, total, bad, target;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {lsu_axi_arvld, lsu_axi_rrdy, lsu_ram_wr_en, lsu_alu_rd_done,
                              lsu_alu_rd_err, lsu_alu_rd_rdy}, 6'b0);
        rst = 1'b0;

        arrdy_mode = 0; rdelay = 2; rgap = 0;
        run_cmd(32'h1000, 8'd3, 8'd3, 16'h0100, 12'h010, 2'd1, -1, 0);

        arrdy_mode = 1; rdelay = 20; peak = 0;
        run_cmd(32'h8000_0000, 8'd5, 8'd2, 16'h0040, 12'h200, 2'd2, -1, 0);
        check("peak_outstanding", peak, 2);

        rdelay = 1;
        run_cmd(32'h4000, 8'd0, 8'd3, 16'h0010, 12'h000, 2'd0, -1, 0);

        run_cmd(32'h5000, 8'd2, 8'd1, 16'h0020, 12'h030, 2'd0, 1, 0);
        run_cmd(32'h6000, 8'd2, 8'd1, 16'h0020, 12'h040, 2'd1, -1, 0);

        run_cmd(32'h7000, 8'd1, 8'd3, 16'h0000, 12'hFFE, 2'd2, -1, 0);

        run_cmd(32'hFFFF_FF80, 8'd3, 8'd0, 16'h0040, 12'h100, 2'd1, 2, 1);

        // Reset with two of four bursts issued and their data still pending.
        arrdy_mode = 0; rdelay = 400; base = ar_cnt;
        issue_cmd(32'h2000, 8'd4, 8'd3, 16'h0040, 12'h100, 2'd2, -1, 0, t);
        i = 0;
        while (ar_cnt < base + 2 && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("ars_before_rst", ar_cnt - base, 2);
        target = done_cnt;
        do_reset(3);
        rdelay = 0;
        issue_cmd(32'h3000, 8'd2, 8'd1, 16'h0080, 12'h020, 2'd0, -1, 0, t);
        check("accept_after_release", t, 1);
        wait_done(target + 1);
        check("no_done_from_abandoned", done_cnt, target + 1);

        arrdy_mode = 1; rgap = 30;
        for (int k = 0; k < 16; k++) begin
            n = $urandom_range(0, 5);
            l = $urandom_range(0, 7);
            total = n * (l + 1);
            bad = ($urandom_range(0, 3) == 0 && total > 0) ? $urandom_range(0, total - 1) : -1;
            rdelay = $urandom_range(0, 8);
            run_cmd($urandom, 8'(n), 8'(l), 16'($urandom), 12'($urandom), 2'($urandom_range(0, 2)),
                    bad, $urandom_range(0, 1));
        end

        repeat (5) @(posedge clk);
        #1;
        check("exp_writes_left", exp_wr.size(), 0);
        check("exp_dones_left", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
